// File: rtl/mtm_alu_rx_deser.sv
`timescale 1ns/1ps
// mtm_alu_rx_deser
// Serial packet receiver for the ALU datapath. Deserialises 11-bit frames
// (start 0, type, d[7:0] MSB first, stop 1) from sin into operands B and A
// (2*BYTES data frames, MSB byte first) plus a cmd frame {0, OP[2:0], CRC[3:0]}.
// It then checks framing, CRC4 (x^4+x+1) and the opcode and hands either a
// valid command or an error code to the ALU core.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   sin        serial input, idle high
//   out_valid  result register holds a packet outcome
//   out_ready  consumer accepts the result when out_valid && out_ready
//   b_o, a_o   operands (zero on error)
//   op_o       opcode (zero on error)
//   err_o      {err_data, err_crc, err_op}; zero means valid command
//   overrun_o  one-cycle pulse: a completed packet was dropped
//   dbg_state  current FSM state encoding, for observation only
//
// Handshake: out_valid stays high with b_o/a_o/op_o/err_o stable until a
// cycle with out_valid && out_ready; it then clears on the next edge unless a
// new result loads on that same edge (then it stays high with the new data).
// A result completing while out_valid && !out_ready is dropped, the held
// result is left untouched and overrun_o pulses for one cycle.
module mtm_alu_rx_deser #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] a_o,
  output logic [2:0]       op_o,
  output logic [2:0]       err_o,
  output logic             overrun_o,
  output logic [2:0]       dbg_state
);

  localparam int BYTES   = WIDTH / 8;
  localparam int NFRAMES = 2 * BYTES;
  localparam int CNT_W   = $clog2(NFRAMES + 2);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    TYPE      = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4,
    CHECK     = 3'd5
  } state_t;

  state_t               state;
  logic                 is_cmd;
  logic [2:0]           bit_cnt;
  logic [7:0]           byte_sr;
  logic [2*WIDTH-1:0]   ab_sr;    // B in the upper half once all bytes arrived
  logic [CNT_W-1:0]     dcnt;     // data frames seen, saturates at NFRAMES+1
  logic [TO_W-1:0]      tcnt;     // idle cycles inside an open packet
  logic [3:0]           crc;      // running CRC over data bits only

  logic [2:0]           op_rx;
  logic [3:0]           crc_rx;
  logic [3:0]           crc_final;
  logic                 op_ok;
  logic                 close;
  logic [2:0]           close_err;
  logic                 load_ok;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  assign dbg_state = state;
  assign op_rx     = byte_sr[6:4];
  assign crc_rx    = byte_sr[3:0];
  // The constant 1 and the OP bits are folded into the CRC while in CHECK.
  assign crc_final = crc_step(crc_step(crc_step(crc_step(crc, 1'b1), op_rx[2]),
                                       op_rx[1]), op_rx[0]);
  assign op_ok     = (op_rx == 3'b000) || (op_rx == 3'b001) ||
                     (op_rx == 3'b100) || (op_rx == 3'b101);
  assign load_ok   = !out_valid || out_ready;

  // Packet close events: normal CHECK, framing error at STOP, or timeout.
  always_comb begin
    close     = 1'b0;
    close_err = 3'b000;
    case (state)
      CHECK: begin
        close = 1'b1;
        if (dcnt != CNT_W'(NFRAMES))  close_err = 3'b100;
        else if (crc_rx != crc_final) close_err = 3'b010;
        else if (!op_ok)              close_err = 3'b001;
        else                          close_err = 3'b000;
      end
      STOP: begin
        if (!sin) begin
          close     = 1'b1;
          close_err = 3'b100;
        end
      end
      IDLE: begin
        if (sin && (dcnt != '0) && (tcnt == TO_W'(TIMEOUT - 1))) begin
          close     = 1'b1;
          close_err = 3'b100;
        end
      end
      default: begin
        close     = 1'b0;
        close_err = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_IDLE;
      is_cmd    <= 1'b0;
      bit_cnt   <= '0;
      byte_sr   <= '0;
      ab_sr     <= '0;
      dcnt      <= '0;
      tcnt      <= '0;
      crc       <= '0;
      out_valid <= 1'b0;
      b_o       <= '0;
      a_o       <= '0;
      op_o      <= '0;
      err_o     <= '0;
      overrun_o <= 1'b0;
    end else begin
      // Result register
      overrun_o <= 1'b0;
      if (close) begin
        if (load_ok) begin
          out_valid <= 1'b1;
          err_o     <= close_err;
          if (close_err == 3'b000) begin
            b_o  <= ab_sr[2*WIDTH-1:WIDTH];
            a_o  <= ab_sr[WIDTH-1:0];
            op_o <= op_rx;
          end else begin
            b_o  <= '0;
            a_o  <= '0;
            op_o <= '0;
          end
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Receiver FSM
      case (state)
        WAIT_IDLE: begin
          if (sin) state <= IDLE;
        end
        IDLE: begin
          if (!sin) begin
            state <= TYPE;
            tcnt  <= '0;
          end else if (dcnt != '0) begin
            if (close) begin
              dcnt  <= '0;
              tcnt  <= '0;
              crc   <= '0;
              ab_sr <= '0;
            end else begin
              tcnt <= tcnt + TO_W'(1);
            end
          end
        end
        TYPE: begin
          is_cmd  <= sin;
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          byte_sr <= {byte_sr[6:0], sin};
          if (!is_cmd) crc <= crc_step(crc, sin);
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= STOP;
        end
        STOP: begin
          if (!sin) begin
            // Framing error: drop the packet and resynchronise on idle.
            dcnt  <= '0;
            tcnt  <= '0;
            crc   <= '0;
            ab_sr <= '0;
            state <= WAIT_IDLE;
          end else if (is_cmd) begin
            state <= CHECK;
          end else begin
            ab_sr <= {ab_sr[2*WIDTH-9:0], byte_sr};
            if (dcnt != CNT_W'(NFRAMES + 1)) dcnt <= dcnt + CNT_W'(1);
            state <= IDLE;
          end
        end
        CHECK: begin
          dcnt  <= '0;
          tcnt  <= '0;
          crc   <= '0;
          ab_sr <= '0;
          state <= IDLE;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_rx_deser.sv
`timescale 1ns/1ps
// Bench for mtm_alu_rx_deser: one 32-bit instance (TIMEOUT 64) and one 8-bit
// instance. Expected results come from a packet-level model: CRC by long
// division of the augmented message, error priority from the packet rules.
module tb_mtm_alu_rx_deser;

  typedef logic [133:0] res_t;  // {err[2:0], op[2:0], b[63:0], a[63:0]}

  logic        clk;
  logic        rst;
  logic        sin32, sin8;
  logic        rdy32, rdy8;
  logic        v32, ov32, v8, ov8;
  logic [31:0] b32, a32;
  logic [7:0]  b8, a8;
  logic [2:0]  op32, err32, st32, op8, err8, st8;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  mtm_alu_rx_deser #(.WIDTH(32), .TIMEOUT(64)) u32 (
    .clk(clk), .rst(rst), .sin(sin32), .out_valid(v32), .out_ready(rdy32),
    .b_o(b32), .a_o(a32), .op_o(op32), .err_o(err32), .overrun_o(ov32),
    .dbg_state(st32)
  );

  mtm_alu_rx_deser #(.WIDTH(8), .TIMEOUT(16)) u8 (
    .clk(clk), .rst(rst), .sin(sin8), .out_valid(v8), .out_ready(rdy8),
    .b_o(b8), .a_o(a8), .op_o(op8), .err_o(err8), .overrun_o(ov8),
    .dbg_state(st8)
  );

  // ---------------- reference model ----------------
  function automatic logic [3:0] div_step(input logic [3:0] r, input logic x);
    logic [4:0] n;
    n = {r, x};
    if (n[4]) n = n ^ 5'b10011;
    return n[3:0];
  endfunction

  // Remainder of {B, A, 1, OP, 0000} divided by x^4+x+1.
  function automatic logic [3:0] ref_crc(input int w, input logic [63:0] b,
                                         input logic [63:0] a, input logic [2:0] op);
    logic [3:0] r;
    r = 4'd0;
    for (int i = w - 1; i >= 0; i--) r = div_step(r, b[i]);
    for (int i = w - 1; i >= 0; i--) r = div_step(r, a[i]);
    r = div_step(r, 1'b1);
    for (int i = 2; i >= 0; i--) r = div_step(r, op[i]);
    for (int i = 0; i < 4; i++) r = div_step(r, 1'b0);
    return r;
  endfunction

  function automatic logic [7:0] make_cmd(input int w, input logic [63:0] b,
                                          input logic [63:0] a, input logic [2:0] op);
    return {1'b0, op, ref_crc(w, b, a, op)};
  endfunction

  function automatic res_t ref_result(input int w, input logic [63:0] b,
                                      input logic [63:0] a, input int ndata,
                                      input logic [7:0] cmd);
    logic [2:0] op;
    op = cmd[6:4];
    if (ndata != w / 4) return {3'b100, 131'd0};
    if (cmd[3:0] != ref_crc(w, b, a, op)) return {3'b010, 131'd0};
    if (!(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101))
      return {3'b001, 131'd0};
    return {3'b000, op, b, a};
  endfunction

  function automatic res_t obs(input bit sel);
    if (sel) return {err8, op8, 56'd0, b8, 56'd0, a8};
    return {err32, op32, 32'd0, b32, 32'd0, a32};
  endfunction

  // ---------------- drivers ----------------
  task automatic send_bit(input bit sel, input logic v);
    if (sel) sin8 = v;
    else     sin32 = v;
    @(negedge clk);
  endtask

  task automatic idle(input bit sel, input int n);
    repeat (n) send_bit(sel, 1'b1);
  endtask

  task automatic send_frame(input bit sel, input logic typ, input logic [7:0] d,
                            input logic stp);
    send_bit(sel, 1'b0);
    send_bit(sel, typ);
    for (int i = 7; i >= 0; i--) send_bit(sel, d[i]);
    send_bit(sel, stp);
  endtask

  task automatic send_data(input bit sel, input int w, input logic [63:0] b,
                           input logic [63:0] a, input int ndata);
    logic [7:0] byte_v;
    for (int i = 0; i < ndata; i++) begin
      if (i < w / 8)      byte_v = 8'(b >> (w - 8 * (i + 1)));
      else if (i < w / 4) byte_v = 8'(a >> (w - 8 * (i - w / 8 + 1)));
      else                byte_v = 8'($urandom);
      send_frame(sel, 1'b0, byte_v, 1'b1);
    end
  endtask

  // Returns at the negedge right after the cmd-frame stop bit was sampled.
  task automatic send_packet(input bit sel, input int w, input logic [63:0] b,
                             input logic [63:0] a, input int ndata, input logic [7:0] cmd);
    send_data(sel, w, b, a, ndata);
    send_frame(sel, 1'b1, cmd, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; sin32 = 1'b1; sin8 = 1'b1; rdy32 = 1'b1; rdy8 = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({v32, ov32, err32, op32, b32, a32} !== 72'd0) begin
      n_fail++;
      $display("FAIL reset_w32: got %h expected 0", {v32, ov32, err32, op32, b32, a32});
    end
    n_tests++;
    if ({v8, ov8, err8, op8, b8, a8} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_w8: got %h expected 0", {v8, ov8, err8, op8, b8, a8});
    end
    rst = 1'b0;
    idle(0, 3);
  endtask

  task automatic test_zero_packet();
    res_t e;
    e = ref_result(32, 64'd0, 64'd0, 8, 8'h0B);
    send_packet(0, 32, 64'd0, 64'd0, 8, 8'h0B);
    n_tests++;
    if (v32 !== 1'b0) begin
      n_fail++; $display("FAIL zero_latency_early: out_valid=%b expected 0", v32);
    end
    send_bit(0, 1'b1);
    n_tests++;
    if (v32 !== 1'b1 || obs(0) !== e) begin
      n_fail++; $display("FAIL zero_result: valid=%b got %h expected %h", v32, obs(0), e);
    end
    send_bit(0, 1'b1);
    n_tests++;
    if (v32 !== 1'b0) begin
      n_fail++; $display("FAIL zero_pulse_end: out_valid=%b expected 0", v32);
    end
    idle(0, 1);
  endtask

  task automatic test_width8();
    res_t e;
    logic [63:0] b, a;
    logic [7:0] cmd;
    logic [7:0] cmds [2];
    cmds[0] = 8'h0B;
    cmds[1] = 8'h0A;
    for (int k = 0; k < 2; k++) begin
      e = ref_result(8, 64'd0, 64'd0, 2, cmds[k]);
      send_packet(1, 8, 64'd0, 64'd0, 2, cmds[k]);
      send_bit(1, 1'b1);
      n_tests++;
      if (v8 !== 1'b1 || obs(1) !== e) begin
        n_fail++; $display("FAIL w8_fixed_%0d: valid=%b got %h expected %h", k, v8, obs(1), e);
      end
      idle(1, 2);
    end
    for (int k = 0; k < 10; k++) begin
      b = {56'd0, 8'($urandom)};
      a = {56'd0, 8'($urandom)};
      cmd = make_cmd(8, b, a, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) cmd[3:0] = cmd[3:0] ^ 4'($urandom_range(1, 15));
      exp_q.push_back(ref_result(8, b, a, 2, cmd));
      send_packet(1, 8, b, a, 2, cmd);
      send_bit(1, 1'b1);
      e = exp_q.pop_front();
      n_tests++;
      if (v8 !== 1'b1 || obs(1) !== e) begin
        n_fail++; $display("FAIL w8_random_%0d: valid=%b got %h expected %h", k, v8, obs(1), e);
      end
      idle(1, 1 + $urandom_range(0, 2));
    end
  endtask

  task automatic test_random32();
    res_t e;
    logic [63:0] b, a;
    logic [7:0] cmd;
    for (int k = 0; k < 16; k++) begin
      b = {32'd0, $urandom};
      a = {32'd0, $urandom};
      cmd = make_cmd(32, b, a, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) cmd[3:0] = cmd[3:0] ^ 4'($urandom_range(1, 15));
      exp_q.push_back(ref_result(32, b, a, 8, cmd));
      send_packet(0, 32, b, a, 8, cmd);
      send_bit(0, 1'b1);
      e = exp_q.pop_front();
      n_tests++;
      if (v32 !== 1'b1 || obs(0) !== e) begin
        n_fail++; $display("FAIL w32_random_%0d: valid=%b got %h expected %h", k, v32, obs(0), e);
      end
      idle(0, 1 + $urandom_range(0, 2));
    end
  endtask

  task automatic test_count_errors();
    res_t e;
    logic [63:0] b, a;
    int nd [2];
    logic [7:0] cmd;
    nd[0] = 7;
    nd[1] = 9;
    b = {32'd0, $urandom};
    a = {32'd0, $urandom};
    for (int k = 0; k < 2; k++) begin
      cmd = (k == 0) ? 8'h0B : make_cmd(32, b, a, 3'b000);
      e = ref_result(32, b, a, nd[k], cmd);
      send_packet(0, 32, b, a, nd[k], cmd);
      send_bit(0, 1'b1);
      n_tests++;
      if (v32 !== 1'b1 || obs(0) !== e) begin
        n_fail++; $display("FAIL count_err_%0d: valid=%b got %h expected %h", nd[k], v32, obs(0), e);
      end
      idle(0, 2);
    end
  endtask

  task automatic test_framing();
    res_t e;
    logic bad;
    logic [63:0] b, a;
    logic [7:0] cmd;
    send_frame(0, 1'b0, 8'($urandom), 1'b0);
    n_tests++;
    if (v32 !== 1'b1 || obs(0) !== {3'b100, 131'd0}) begin
      n_fail++; $display("FAIL framing_err: valid=%b got %h expected %h", v32, obs(0), {3'b100, 131'd0});
    end
    bad = 1'b0;
    repeat (14) begin
      send_bit(0, 1'b0);
      if (v32 !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL framing_resync: output seen=%b expected 0", bad);
    end
    idle(0, 2);
    b = {32'd0, $urandom};
    a = {32'd0, $urandom};
    cmd = make_cmd(32, b, a, 3'b101);
    e = ref_result(32, b, a, 8, cmd);
    send_packet(0, 32, b, a, 8, cmd);
    send_bit(0, 1'b1);
    n_tests++;
    if (v32 !== 1'b1 || obs(0) !== e) begin
      n_fail++; $display("FAIL framing_recover: valid=%b got %h expected %h", v32, obs(0), e);
    end
    idle(0, 2);
  endtask

  task automatic test_timeout();
    res_t e;
    logic bad;
    logic [63:0] b, a;
    logic [7:0] cmd;
    send_data(0, 32, {32'd0, $urandom}, {32'd0, $urandom}, 3);
    bad = 1'b0;
    repeat (63) begin
      send_bit(0, 1'b1);
      if (v32 !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: output seen=%b expected 0", bad);
    end
    send_bit(0, 1'b1);
    n_tests++;
    if (v32 !== 1'b1 || obs(0) !== {3'b100, 131'd0}) begin
      n_fail++; $display("FAIL timeout_err: valid=%b got %h expected %h", v32, obs(0), {3'b100, 131'd0});
    end
    send_bit(0, 1'b1);
    b = {32'd0, $urandom};
    a = {32'd0, $urandom};
    cmd = make_cmd(32, b, a, 3'b100);
    e = ref_result(32, b, a, 8, cmd);
    send_packet(0, 32, b, a, 8, cmd);
    send_bit(0, 1'b1);
    n_tests++;
    if (v32 !== 1'b1 || obs(0) !== e) begin
      n_fail++; $display("FAIL timeout_recover: valid=%b got %h expected %h", v32, obs(0), e);
    end
    idle(0, 2);
  endtask

  task automatic test_overrun();
    res_t e1;
    logic [63:0] b, a;
    logic [7:0] cmd;
    rdy32 = 1'b0;
    b = {32'd0, $urandom};
    a = {32'd0, $urandom};
    cmd = make_cmd(32, b, a, 3'b001);
    e1 = ref_result(32, b, a, 8, cmd);
    send_packet(0, 32, b, a, 8, cmd);
    send_bit(0, 1'b1);
    n_tests++;
    if (v32 !== 1'b1 || obs(0) !== e1) begin
      n_fail++; $display("FAIL overrun_hold: valid=%b got %h expected %h", v32, obs(0), e1);
    end
    b = {32'd0, $urandom};
    a = {32'd0, $urandom};
    send_packet(0, 32, b, a, 8, make_cmd(32, b, a, 3'b000));
    send_bit(0, 1'b1);
    n_tests++;
    if ({ov32, v32, obs(0)} !== {2'b11, e1}) begin
      n_fail++; $display("FAIL overrun_pulse: got %h expected %h", {ov32, v32, obs(0)}, {2'b11, e1});
    end
    send_bit(0, 1'b1);
    n_tests++;
    if ({ov32, v32, obs(0)} !== {2'b01, e1}) begin
      n_fail++; $display("FAIL overrun_single: got %h expected %h", {ov32, v32, obs(0)}, {2'b01, e1});
    end
    rdy32 = 1'b1;
    send_bit(0, 1'b1);
    n_tests++;
    if (v32 !== 1'b0) begin
      n_fail++; $display("FAIL overrun_accept: out_valid=%b expected 0", v32);
    end
    idle(0, 1);
  endtask

  task automatic test_accept_and_load();
    res_t e2;
    logic [63:0] b, a;
    logic [7:0] cmd;
    rdy32 = 1'b0;
    b = {32'd0, $urandom};
    a = {32'd0, $urandom};
    send_packet(0, 32, b, a, 8, make_cmd(32, b, a, 3'b000));
    send_bit(0, 1'b1);
    b = {32'd0, $urandom};
    a = {32'd0, $urandom};
    cmd = make_cmd(32, b, a, 3'b101);
    e2 = ref_result(32, b, a, 8, cmd);
    send_packet(0, 32, b, a, 8, cmd);
    rdy32 = 1'b1;
    send_bit(0, 1'b1);
    n_tests++;
    if ({ov32, v32, obs(0)} !== {2'b01, e2}) begin
      n_fail++; $display("FAIL accept_load: got %h expected %h", {ov32, v32, obs(0)}, {2'b01, e2});
    end
    send_bit(0, 1'b1);
    n_tests++;
    if (v32 !== 1'b0) begin
      n_fail++; $display("FAIL accept_load_clear: out_valid=%b expected 0", v32);
    end
    idle(0, 1);
  endtask

  task automatic test_back_to_back();
    res_t e;
    logic [63:0] b, a;
    logic [7:0] cmd;
    for (int k = 0; k < 3; k++) begin
      b = {32'd0, $urandom};
      a = {32'd0, $urandom};
      cmd = make_cmd(32, b, a, 3'b100);
      exp_q.push_back(ref_result(32, b, a, 8, cmd));
      send_packet(0, 32, b, a, 8, cmd);
      send_bit(0, 1'b1);  // single idle bit, next start follows at once
      e = exp_q.pop_front();
      n_tests++;
      if (v32 !== 1'b1 || obs(0) !== e) begin
        n_fail++; $display("FAIL back_to_back_%0d: valid=%b got %h expected %h", k, v32, obs(0), e);
      end
    end
    idle(0, 2);
  endtask

  task automatic test_reset_mid_packet();
    res_t e;
    logic bad;
    logic [63:0] b, a;
    logic [7:0] cmd;
    rdy32 = 1'b0;
    b = {32'd0, $urandom};
    a = {32'd0, $urandom};
    send_packet(0, 32, b, a, 8, make_cmd(32, b, a, 3'b000));
    send_bit(0, 1'b1);
    send_data(0, 32, {32'd0, $urandom}, {32'd0, $urandom}, 4);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    repeat (3) send_bit(0, 1'($urandom));
    sin32 = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({v32, ov32, err32, op32, b32, a32} !== 72'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", {v32, ov32, err32, op32, b32, a32});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy32 = 1'b1;
    bad = 1'b0;
    repeat (15) begin
      send_bit(0, 1'b0);
      if (v32 !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_no_start: output seen=%b expected 0", bad);
    end
    idle(0, 2);
    b = {32'd0, $urandom};
    a = {32'd0, $urandom};
    cmd = make_cmd(32, b, a, 3'b001);
    e = ref_result(32, b, a, 8, cmd);
    send_packet(0, 32, b, a, 8, cmd);
    send_bit(0, 1'b1);
    n_tests++;
    if (v32 !== 1'b1 || obs(0) !== e) begin
      n_fail++; $display("FAIL rst_mid_recover: valid=%b got %h expected %h", v32, obs(0), e);
    end
    idle(0, 2);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero_packet();
    test_width8();
    test_random32();
    test_count_errors();
    test_framing();
    test_timeout();
    test_overrun();
    test_accept_and_load();
    test_back_to_back();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
